// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// State encodings, byte width and default watchdog limit.
package uart_tx_arb_pkg;

  localparam int UART_BYTE_W = 8;
  localparam int TIMEOUT_CYCLES_DEF = 65535;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } state_e;

endpackage

// File: rtl/uart_tx_arbiter_picker.sv
// Round-robin picker: first set req bit above ptr, with wrap.
// Purely combinational; returns one-hot grant and its index.
module uart_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               any
);

  // scan from rr_ptr+1 upward, stop at the first hit
  always_comb begin
    int j;
    j       = 0;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(rr_ptr) + k) % NUM_REQ;
      if (!any && req[j]) begin
        any     = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte producers.
// Optional WAIT watchdog enabled by UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           tx_start,
  output logic [UART_BYTE_W-1:0]         tx_data,
  input  logic                           tx_done,
  output logic                           busy,
  output logic [ID_W-1:0]                grant_id,
  output logic                           timeout_err
);

  state_e                 state_q, state_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]        grant_q, grant_d;
  logic [UART_BYTE_W-1:0] data_q, data_d;

  logic [NUM_REQ-1:0]     pick_gnt;
  logic [ID_W-1:0]        pick_idx;
  logic                   pick_any;

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [15:0]            cnt_q, cnt_d;
`else
  logic                   unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
`endif

  uart_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req     (req_valid),
    .rr_ptr  (rr_ptr_q),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  assign tx_data  = data_q;
  assign grant_id = grant_q;
  assign busy     = (state_q != ST_IDLE);

  // next-state, handshake and launch decode
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    data_d      = data_q;
    req_ready   = '0;
    tx_start    = 1'b0;
    timeout_err = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        req_ready = pick_gnt;
        if (pick_any) begin
          data_d   = req_data[pick_idx*UART_BYTE_W +: UART_BYTE_W];
          grant_d  = pick_idx;
          rr_ptr_d = pick_idx;
          state_d  = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        tx_start = 1'b1;
        state_d  = ST_WAIT;
`ifdef UART_TX_ARB_TIMEOUT_EN
        cnt_d    = '0;
`endif
      end
      ST_WAIT: begin
        if (tx_done) begin
          state_d = ST_IDLE;
`ifdef UART_TX_ARB_TIMEOUT_EN
        end else if (cnt_q == 16'(TIMEOUT_CYCLES)) begin
          timeout_err = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= ID_W'(NUM_REQ - 1);
      grant_q  <= '0;
      data_q   <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      data_q   <= data_d;
`ifdef UART_TX_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a scripted transmitter.
// Honours UART_TX_ARB_TIMEOUT_EN for the watchdog scenario.
module tb_uart_tx_arbiter;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TO = 20;
`else
  localparam int TO = 65535;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic        tx_done;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        busy;
  logic [1:0]  grant_id;
  logic        timeout_err;

  int checks   = 0;
  int failures = 0;

  uart_tx_arbiter #(
    .NUM_REQ        (4),
    .ID_W           (2),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .busy        (busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    tx_done   = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // one frame from IDLE with inputs already set; w WAIT cycles
  task automatic frame(input int w, input bit drop,
                       output logic [3:0] rdy,
                       output logic [1:0] gid,
                       output logic [7:0] dat,
                       output int starts);
    #1 rdy = req_ready;
    starts = 0;
    @(negedge clk);
    gid = grant_id;
    dat = tx_data;
    starts += int'(tx_start);
    if (drop) req_valid = req_valid & ~rdy;
    for (int i = 0; i < w; i++) begin
      @(negedge clk);
      starts += int'(tx_start);
    end
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    tx_done   = 1'b0;
    @(negedge clk);
    checks++;
    if ({req_ready, tx_start, busy, timeout_err} !== 7'd0) begin
      failures++;
      $display("FAIL reset_ctl got=%b want=0",
               {req_ready, tx_start, busy, timeout_err});
    end
    checks++;
    if (tx_data !== 8'h00 || grant_id !== 2'd0) begin
      failures++;
      $display("FAIL reset_data got=%h/%0d want=00/0", tx_data, grant_id);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [3:0] r; logic [1:0] g; logic [7:0] d; int s;
    req_data  = 32'h000000A5;
    req_valid = 4'b0001;
    frame(3, 1'b1, r, g, d, s);
    checks++;
    if (r !== 4'b0001) begin
      failures++;
      $display("FAIL single_ready got=%b want=0001", r);
    end
    checks++;
    if (g !== 2'd0 || d !== 8'hA5 || s !== 1) begin
      failures++;
      $display("FAIL single_tx got=%0d/%h/%0d want=0/a5/1", g, d, s);
    end
    checks++;
    if (busy !== 1'b0 || tx_data !== 8'hA5) begin
      failures++;
      $display("FAIL single_done got=%b/%h want=0/a5", busy, tx_data);
    end
  endtask

  task automatic test_all_valid();
    logic [3:0] r; logic [1:0] g; logic [7:0] d; int s;
    logic [1:0] exp_id [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    req_data  = 32'h13121110;
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      frame(2, 1'b0, r, g, d, s);
      checks++;
      if (g !== exp_id[i] || d !== {6'h04, exp_id[i]} ||
          r !== (4'b0001 << exp_id[i]) || s !== 1) begin
        failures++;
        $display("FAIL all_valid[%0d] got=%0d/%h/%b/%0d want=%0d/%h",
                 i, g, d, r, s, exp_id[i], {6'h04, exp_id[i]});
      end
    end
    req_valid = '0;
  endtask

  task automatic test_round_robin();
    logic [3:0] r; logic [1:0] g; logic [7:0] d; int s;
    req_data  = 32'h44332211;
    req_valid = 4'b0100;
    frame(1, 1'b1, r, g, d, s);
    checks++;
    if (g !== 2'd2 || d !== 8'h33) begin
      failures++;
      $display("FAIL rr_first got=%0d/%h want=2/33", g, d);
    end
    req_valid = 4'b1010;
    frame(1, 1'b1, r, g, d, s);
    checks++;
    if (g !== 2'd3 || d !== 8'h44) begin
      failures++;
      $display("FAIL rr_second got=%0d/%h want=3/44", g, d);
    end
    frame(1, 1'b1, r, g, d, s);
    checks++;
    if (g !== 2'd1 || d !== 8'h22) begin
      failures++;
      $display("FAIL rr_third got=%0d/%h want=1/22", g, d);
    end
    req_valid = '0;
  endtask

  task automatic test_stray_done();
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    checks++;
    if (busy !== 1'b0 || tx_start !== 1'b0 || req_ready !== 4'b0) begin
      failures++;
      $display("FAIL done_idle got=%b/%b/%b want=0/0/0",
               busy, tx_start, req_ready);
    end
    req_valid = 4'b0001;
    @(negedge clk);
    tx_done   = 1'b1;
    req_valid = 4'b1111;
    checks++;
    if (tx_start !== 1'b1) begin
      failures++;
      $display("FAIL launch_start got=%b want=1", tx_start);
    end
    @(negedge clk);
    tx_done = 1'b0;
    checks++;
    if (busy !== 1'b1 || tx_start !== 1'b0 || req_ready !== 4'b0) begin
      failures++;
      $display("FAIL done_launch got=%b/%b/%b want=1/0/0",
               busy, tx_start, req_ready);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || tx_start !== 1'b0) begin
      failures++;
      $display("FAIL wait_hold got=%b/%b want=1/0", busy, tx_start);
    end
    req_valid = '0;
    tx_done   = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL wait_exit got=%b want=0", busy);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [3:0] r; logic [1:0] g; logic [7:0] d; int s;
    req_data  = 32'h00C30000;
    req_valid = 4'b0100;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || tx_start !== 1'b0 || tx_data !== 8'h00 ||
        grant_id !== 2'd0 || req_ready !== 4'b0) begin
      failures++;
      $display("FAIL async_reset got=%b/%b/%h/%0d/%b want=0/0/00/0/0",
               busy, tx_start, tx_data, grant_id, req_ready);
    end
    @(negedge clk);
    reset_n   = 1'b1;
    req_data  = 32'h44332211;
    req_valid = 4'b1111;
    frame(1, 1'b1, r, g, d, s);
    checks++;
    if (r !== 4'b0001 || g !== 2'd0 || d !== 8'h11) begin
      failures++;
      $display("FAIL post_reset got=%b/%0d/%h want=0001/0/11", r, g, d);
    end
    req_valid = '0;
  endtask

  task automatic test_watchdog();
    int first_err;
    int lows;
    first_err = -1;
    lows      = 0;
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    for (int k = 0; k <= 30; k++) begin
      @(negedge clk);
      if (timeout_err === 1'b1 && first_err < 0) first_err = k;
      if (busy !== 1'b1) lows++;
      if (first_err >= 0) break;
    end
`ifdef UART_TX_ARB_TIMEOUT_EN
    checks++;
    if (first_err !== TO || lows !== 0) begin
      failures++;
      $display("FAIL timeout_at got=%0d/%0d want=%0d/0", first_err, lows, TO);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_idle got=%b/%b want=0/0", busy, timeout_err);
    end
`else
    checks++;
    if (first_err !== -1 || lows !== 0) begin
      failures++;
      $display("FAIL no_timeout got=%0d/%0d want=-1/0", first_err, lows);
    end
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL no_timeout_exit got=%b want=0", busy);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_valid();
    test_round_robin();
    test_stray_done();
    test_reset_mid_wait();
    test_watchdog();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
